// File: rtl/vga_pkg.sv
// Shared types and constants for the vga_bouncer pixel stage.
package vga_pkg;

  typedef struct packed {
    logic [1:0] r;
    logic [1:0] g;
    logic [1:0] b;
  } rgb_t;

  localparam int unsigned H_ACTIVE_DEF = 640;
  localparam int unsigned V_ACTIVE_DEF = 480;

  localparam rgb_t RGB_BLACK = rgb_t'(6'h00);
  localparam rgb_t BG_DARK   = rgb_t'(6'h00);
  localparam rgb_t BG_LIGHT  = rgb_t'(6'h15);

  // Box colours selectable by the colour index; entry 0 is the plain white box.
  localparam rgb_t PALETTE [8] = '{
    rgb_t'(6'h3F),  // white
    rgb_t'(6'h30),  // red
    rgb_t'(6'h0C),  // green
    rgb_t'(6'h03),  // blue
    rgb_t'(6'h3C),  // yellow
    rgb_t'(6'h0F),  // cyan
    rgb_t'(6'h33),  // magenta
    rgb_t'(6'h34)   // orange
  };

  localparam rgb_t BOX_FIXED = PALETTE[0];

endpackage

// File: rtl/vga_bouncer_if.sv
// Timing-generator inputs, motion controls and pixel outputs of vga_bouncer.
interface vga_bouncer_if #(
  parameter int unsigned HPOS_W = 10,
  parameter int unsigned VPOS_W = 10,
  parameter int unsigned STEP_W = 3
);

  logic              clk_en;
  logic              active;
  logic              hsync;
  logic              vsync;
  logic              v_begin;
  logic [HPOS_W-1:0] hpos;
  logic [VPOS_W-1:0] vpos;
  logic [STEP_W-1:0] speed;
  logic              pause;
  logic [1:0]        r;
  logic [1:0]        g;
  logic [1:0]        b;
  logic              hsync_o;
  logic              vsync_o;
  logic              bounce;

  // Timing generator / control side
  modport master (
    output clk_en, active, hsync, vsync, v_begin, hpos, vpos, speed, pause,
    input  r, g, b, hsync_o, vsync_o, bounce
  );

  // Pixel stage side
  modport slave (
    input  clk_en, active, hsync, vsync, v_begin, hpos, vpos, speed, pause,
    output r, g, b, hsync_o, vsync_o, bounce
  );

endinterface

// File: rtl/bounce_axis.sv
// One axis of box motion: position, direction and a wall-hit strobe.
module bounce_axis #(
  parameter int unsigned SPAN   = 640,
  parameter int unsigned SIZE   = 32,
  parameter int unsigned W      = 10,
  parameter int unsigned STEP_W = 3
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              i_update,
  input  logic [STEP_W-1:0] i_speed,
  output logic [W-1:0]      o_pos,
  output logic              o_dir,
  output logic              o_hit_c
);

  // One extra bit so pos+speed never wraps
  localparam int unsigned AW = W + 1;
  localparam logic [AW-1:0] LIM = AW'(SPAN - SIZE);

  logic [W-1:0]  r_pos;
  logic          r_dir;
  logic [W-1:0]  w_pos_nxt;
  logic          w_dir_nxt;
  logic [AW-1:0] w_pos_ext;
  logic [AW-1:0] w_step;
  logic [AW-1:0] w_sum;
  logic [AW-1:0] w_diff;

  assign w_pos_ext = {1'b0, r_pos};
  assign w_step    = AW'(i_speed);
  assign w_sum     = w_pos_ext + w_step;
  assign w_diff    = w_pos_ext - w_step;

  // Next position/direction; clamp to the wall and flip on a hit, speed 0 is a no-op
  always_comb begin
    w_pos_nxt = r_pos;
    w_dir_nxt = r_dir;
    o_hit_c   = 1'b0;
    if (i_update && (w_step != '0)) begin
      if (r_dir) begin
        if (w_sum >= LIM) begin
          w_pos_nxt = W'(LIM);
          w_dir_nxt = 1'b0;
          o_hit_c   = 1'b1;
        end else begin
          w_pos_nxt = W'(w_sum);
        end
      end else begin
        if (w_pos_ext <= w_step) begin
          w_pos_nxt = '0;
          w_dir_nxt = 1'b1;
          o_hit_c   = 1'b1;
        end else begin
          w_pos_nxt = W'(w_diff);
        end
      end
    end
  end

  // Motion state register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_pos <= '0;
      r_dir <= 1'b1;
    end else begin
      r_pos <= w_pos_nxt;
      r_dir <= w_dir_nxt;
    end
  end

  assign o_pos = r_pos;
  assign o_dir = r_dir;

endmodule

// File: rtl/vga_bouncer.sv
// Bouncing-box pixel stage behind the vga timing generator.
// Optional: VGA_BOUNCER_COLOR_CYCLE_EN steps the box colour through PALETTE on each bounce.
module vga_bouncer
  import vga_pkg::*;
#(
  parameter int unsigned H_ACTIVE = H_ACTIVE_DEF,
  parameter int unsigned V_ACTIVE = V_ACTIVE_DEF,
  parameter int unsigned BOX_W    = 32,
  parameter int unsigned BOX_H    = 32,
  parameter int unsigned HPOS_W   = 10,
  parameter int unsigned VPOS_W   = 10,
  parameter int unsigned STEP_W   = 3
) (
  input  logic          clk,
  input  logic          rst_n,
  vga_bouncer_if.slave  bus
);

  localparam int unsigned HXW = HPOS_W + 1;
  localparam int unsigned VXW = VPOS_W + 1;

  logic              w_update;
  logic              w_hit_x;
  logic              w_hit_y;
  logic              w_hit;
  logic              w_dir_x;
  logic              w_dir_y;
  logic [HPOS_W-1:0] w_box_x;
  logic [VPOS_W-1:0] w_box_y;
  logic [HXW-1:0]    w_hpos_ext;
  logic [HXW-1:0]    w_box_x_ext;
  logic [VXW-1:0]    w_vpos_ext;
  logic [VXW-1:0]    w_box_y_ext;
  logic              w_in_x;
  logic              w_in_y;
  logic              w_checker;
  rgb_t              w_box_rgb;
  rgb_t              w_pix_rgb;

  rgb_t              r_rgb;
  logic              r_hsync;
  logic              r_vsync;
  logic              r_bounce;

  // Motion only at the frame boundary, and never while paused
  assign w_update = bus.v_begin & ~bus.pause;

  bounce_axis #(
    .SPAN   (H_ACTIVE),
    .SIZE   (BOX_W),
    .W      (HPOS_W),
    .STEP_W (STEP_W)
  ) u_axis_x (
    .clk      (clk),
    .rst_n    (rst_n),
    .i_update (w_update),
    .i_speed  (bus.speed),
    .o_pos    (w_box_x),
    .o_dir    (w_dir_x),
    .o_hit_c  (w_hit_x)
  );

  bounce_axis #(
    .SPAN   (V_ACTIVE),
    .SIZE   (BOX_H),
    .W      (VPOS_W),
    .STEP_W (STEP_W)
  ) u_axis_y (
    .clk      (clk),
    .rst_n    (rst_n),
    .i_update (w_update),
    .i_speed  (bus.speed),
    .o_pos    (w_box_y),
    .o_dir    (w_dir_y),
    .o_hit_c  (w_hit_y)
  );

  // A corner hit is still a single event
  assign w_hit = w_hit_x | w_hit_y;

  // Bounce strobe, one cycle after the v_begin that caused it
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_bounce <= 1'b0;
    end else begin
      r_bounce <= w_hit;
    end
  end

`ifdef VGA_BOUNCER_COLOR_CYCLE_EN
  logic [2:0] r_color_idx;

  // Colour index advances once per bounce event, wrapping through the palette
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_color_idx <= 3'd0;
    end else if (w_hit) begin
      r_color_idx <= r_color_idx + 3'd1;
    end
  end

  assign w_box_rgb = PALETTE[r_color_idx];
`else
  assign w_box_rgb = BOX_FIXED;
`endif

  assign w_hpos_ext  = {1'b0, bus.hpos};
  assign w_vpos_ext  = {1'b0, bus.vpos};
  assign w_box_x_ext = {1'b0, w_box_x};
  assign w_box_y_ext = {1'b0, w_box_y};
  assign w_in_x      = (w_hpos_ext >= w_box_x_ext) && (w_hpos_ext < (w_box_x_ext + HXW'(BOX_W)));
  assign w_in_y      = (w_vpos_ext >= w_box_y_ext) && (w_vpos_ext < (w_box_y_ext + VXW'(BOX_H)));
  assign w_checker   = bus.hpos[5] ^ bus.vpos[5];

  // Pixel colour: blank outside the active area, box on top of the checkerboard
  always_comb begin
    w_pix_rgb = RGB_BLACK;
    if (bus.active) begin
      if (w_in_x && w_in_y) begin
        w_pix_rgb = w_box_rgb;
      end else if (w_checker) begin
        w_pix_rgb = BG_LIGHT;
      end else begin
        w_pix_rgb = BG_DARK;
      end
    end
  end

  // Output pipeline stage: colour and syncs advance together on each pixel enable
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_rgb   <= RGB_BLACK;
      r_hsync <= 1'b1;
      r_vsync <= 1'b1;
    end else if (bus.clk_en) begin
      r_rgb   <= w_pix_rgb;
      r_hsync <= bus.hsync;
      r_vsync <= bus.vsync;
    end
  end

  assign bus.r       = r_rgb.r;
  assign bus.g       = r_rgb.g;
  assign bus.b       = r_rgb.b;
  assign bus.hsync_o = r_hsync;
  assign bus.vsync_o = r_vsync;
  assign bus.bounce  = r_bounce;

endmodule
